// File: rtl/tile_sequencer_if.sv
// Job-control / buffer-strobe bundle for the tile sequencer.
// The slave side is the sequencer; the master side is the job controller
// together with the buffers and the array that consume the strobes.
interface tile_sequencer_if #(
   parameter int A_ROWS_MAX = 64,
   parameter int TILES_MAX  = 16
);
   localparam int AW = $clog2(A_ROWS_MAX + 1);
   localparam int TW = $clog2(TILES_MAX + 1);

   logic          start;
   logic [AW-1:0] cfg_a_rows;
   logic [TW-1:0] cfg_tiles;
   logic          stall;
   logic          w_buffer_read;
   logic          if_buffer_read;
   logic          switch;
   logic          sys_en;
   logic          of_valid;
   logic          of_last;
   logic          busy;
   logic          done;

   modport master (
      output start, cfg_a_rows, cfg_tiles, stall,
      input  w_buffer_read, if_buffer_read, switch, sys_en,
             of_valid, of_last, busy, done
   );

   modport slave (
      input  start, cfg_a_rows, cfg_tiles, stall,
      output w_buffer_read, if_buffer_read, switch, sys_en,
             of_valid, of_last, busy, done
   );
endinterface

// File: rtl/tile_sequencer.sv
// Multi-tile systolic job sequencer: weight preload, activation streaming,
// ping-pong weight bank swap, and output-validity tracking through the array.
// Strobes are registered inside the FSM and only gated by stall on the way out,
// so a stall freezes everything without losing the strobe of the held cycle.
module tile_sequencer #(
   parameter int SYS_ROWS   = 8,
   parameter int SYS_COLS   = 8,
   parameter int A_ROWS_MAX = 64,
   parameter int TILES_MAX  = 16,
   parameter int LAT        = SYS_ROWS + SYS_COLS
) (
   input logic              clk,
   input logic              rst,
   tile_sequencer_if.slave  bus
);

   localparam int AW = $clog2(A_ROWS_MAX + 1);
   localparam int TW = $clog2(TILES_MAX + 1);
   localparam int WW = $clog2(SYS_ROWS + 1);
   localparam int DW = $clog2(LAT);

   localparam logic [AW-1:0] A_MAX  = AW'(A_ROWS_MAX);
   localparam logic [TW-1:0] T_MAX  = TW'(TILES_MAX);
   localparam logic [WW-1:0] W_LAST = WW'(SYS_ROWS - 1);
   localparam logic [WW-1:0] W_FULL = WW'(SYS_ROWS);
   localparam logic [DW-1:0] D_LAST = DW'(LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SWAP, S_COMP, S_WWAIT, S_DRAIN, S_FIN
   } state_t;

   state_t          r_state;
   logic [AW-1:0]   r_a_rows;
   logic [TW-1:0]   r_tiles;
   logic [AW-1:0]   r_a_cnt;
   logic [TW-1:0]   r_tile_cnt;
   logic [WW-1:0]   r_w_cnt;
   logic [DW-1:0]   r_d_cnt;
   logic            r_w_rd;
   logic            r_if_rd;
   logic            r_switch;
   logic            r_done;
   logic            r_busy;
   logic [LAT-1:0]  r_vld_pipe;
   logic [LAT-1:0]  r_last_pipe;

   logic            w_run;
   logic            w_more_tiles;
   logic            w_first_more;
   logic            w_a_last;
   logic [WW-1:0]   w_w_nxt;
   logic            w_w_full_nxt;
   logic            w_last_row;
   logic [AW-1:0]   w_sat_a;
   logic [TW-1:0]   w_sat_t;

   assign w_run        = ~bus.stall;
   // tile_cnt is bumped in SWAP, so during COMP it names the tile being computed
   assign w_more_tiles = r_tile_cnt < r_tiles;
   assign w_first_more = (r_tile_cnt + 1'b1) < r_tiles;
   assign w_a_last     = (r_a_cnt + 1'b1) == r_a_rows;
   // shadow-preload count after this cycle's read (if any)
   assign w_w_nxt      = r_w_cnt + WW'(r_w_rd);
   assign w_w_full_nxt = w_w_nxt == W_FULL;
   assign w_last_row   = (r_state == S_COMP) && !w_more_tiles && w_a_last;
   assign w_sat_a      = (bus.cfg_a_rows > A_MAX) ? A_MAX : bus.cfg_a_rows;
   assign w_sat_t      = (bus.cfg_tiles  > T_MAX) ? T_MAX : bus.cfg_tiles;

   // Job FSM: state, counters and registered strobes for the following cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_a_rows   <= '0;
         r_tiles    <= '0;
         r_a_cnt    <= '0;
         r_tile_cnt <= '0;
         r_w_cnt    <= '0;
         r_d_cnt    <= '0;
         r_w_rd     <= 1'b0;
         r_if_rd    <= 1'b0;
         r_switch   <= 1'b0;
         r_done     <= 1'b0;
         r_busy     <= 1'b0;
      end else if (w_run) begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_a_rows   <= w_sat_a;
                  r_tiles    <= w_sat_t;
                  r_a_cnt    <= '0;
                  r_tile_cnt <= '0;
                  r_w_cnt    <= '0;
                  r_d_cnt    <= '0;
                  r_busy     <= 1'b1;
                  if (w_sat_a == '0 || w_sat_t == '0) begin
                     r_state <= S_FIN;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_LOAD;
                     r_w_rd  <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               r_w_cnt <= r_w_cnt + 1'b1;
               if (r_w_cnt == W_LAST) begin
                  r_state  <= S_SWAP;
                  r_w_rd   <= 1'b0;
                  r_switch <= 1'b1;
               end
            end
            S_SWAP: begin
               r_switch   <= 1'b0;
               r_tile_cnt <= r_tile_cnt + 1'b1;
               r_w_cnt    <= '0;
               r_a_cnt    <= '0;
               r_if_rd    <= 1'b1;
               // start preloading the shadow bank only if another tile follows
               r_w_rd     <= w_first_more;
               r_state    <= S_COMP;
            end
            S_COMP: begin
               r_a_cnt <= r_a_cnt + 1'b1;
               r_w_cnt <= w_w_nxt;
               if (!w_a_last) begin
                  r_w_rd <= w_more_tiles && !w_w_full_nxt;
               end else begin
                  r_if_rd <= 1'b0;
                  if (w_more_tiles && w_w_full_nxt) begin
                     r_state  <= S_SWAP;
                     r_w_rd   <= 1'b0;
                     r_switch <= 1'b1;
                  end else if (w_more_tiles) begin
                     // short tile: finish the shadow preload before swapping
                     r_state <= S_WWAIT;
                     r_w_rd  <= 1'b1;
                  end else begin
                     r_state <= S_DRAIN;
                     r_w_rd  <= 1'b0;
                     r_d_cnt <= '0;
                  end
               end
            end
            S_WWAIT: begin
               r_w_cnt <= r_w_cnt + 1'b1;
               if (r_w_cnt == W_LAST) begin
                  r_state  <= S_SWAP;
                  r_w_rd   <= 1'b0;
                  r_switch <= 1'b1;
               end
            end
            S_DRAIN: begin
               if (r_d_cnt == D_LAST) begin
                  r_d_cnt <= '0;
                  r_state <= S_FIN;
                  r_done  <= 1'b1;
               end else begin
                  r_d_cnt <= r_d_cnt + 1'b1;
               end
            end
            S_FIN: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state  <= S_IDLE;
               r_w_rd   <= 1'b0;
               r_if_rd  <= 1'b0;
               r_switch <= 1'b0;
               r_done   <= 1'b0;
               r_busy   <= 1'b0;
            end
         endcase
      end
   end

   // Output-validity pipe: follows each activation row through the array latency
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_vld_pipe  <= '0;
         r_last_pipe <= '0;
      end else if (w_run) begin
         r_vld_pipe  <= {r_vld_pipe[LAT-2:0],  r_if_rd};
         r_last_pipe <= {r_last_pipe[LAT-2:0], w_last_row};
      end
   end

   assign bus.sys_en         = w_run;
   assign bus.w_buffer_read  = r_w_rd   & w_run;
   assign bus.if_buffer_read = r_if_rd  & w_run;
   assign bus.switch         = r_switch & w_run;
   assign bus.done           = r_done   & w_run;
   assign bus.busy           = r_busy;
   assign bus.of_valid       = r_vld_pipe[LAT-1];
   assign bus.of_last        = r_last_pipe[LAT-1];

endmodule

// File: tb/tb_tile_sequencer.sv
// Scoreboard bench for tile_sequencer: each job pushes hand-computed event
// cycles (switch, of_valid/of_last, done) relative to the start pulse; a
// monitor pops and compares whenever the DUT raises one of those outputs.
module tb_tile_sequencer;

   typedef struct {
      int cyc;
      bit last;
   } ov_t;

   logic clk;
   logic rst;
   int   edge_cnt = 0;
   int   t0 = 0;
   int   n_cmp = 0;
   int   n_fail = 0;

   int   w_tot = 0, if_tot = 0, last_tot = 0, err_sys = 0, err_stall = 0;
   int   w0, if0, l0, es0, ess0;

   int   q_sw[$];
   int   q_done[$];
   ov_t  q_ov[$];

   tile_sequencer_if #(.A_ROWS_MAX(64), .TILES_MAX(16)) bus ();

   tile_sequencer #(
      .SYS_ROWS(8), .SYS_COLS(8), .A_ROWS_MAX(64), .TILES_MAX(16), .LAT(16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, edge_cnt - t0);
      end
   endtask

   task automatic extra(input string nm);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: unexpected event at cycle %0d, none required", nm, edge_cnt - t0);
   endtask

   // Monitor: pops expected events as the DUT presents them
   initial begin : mon
      int  e;
      ov_t o;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (bus.switch) begin
               if (q_sw.size() == 0) extra("switch_extra");
               else begin e = q_sw.pop_front(); chk("switch_cyc", edge_cnt - t0, e - t0); end
            end
            if (bus.done) begin
               if (q_done.size() == 0) extra("done_extra");
               else begin e = q_done.pop_front(); chk("done_cyc", edge_cnt - t0, e - t0); end
            end
            if (bus.of_valid) begin
               if (q_ov.size() == 0) extra("of_valid_extra");
               else begin
                  o = q_ov.pop_front();
                  chk("of_valid_cyc", edge_cnt - t0, o.cyc - t0);
                  chk("of_last", 32'(bus.of_last), 32'(o.last));
               end
            end
            w_tot  += int'(bus.w_buffer_read);
            if_tot += int'(bus.if_buffer_read);
            if (bus.of_valid && bus.of_last) last_tot++;
            if (bus.sys_en !== ~bus.stall) err_sys++;
            if (bus.stall && (bus.w_buffer_read || bus.if_buffer_read || bus.switch)) err_stall++;
         end
      end
   end

   task automatic push_ov(input int from, input int to, input int last_at);
      for (int k = from; k <= to; k++) q_ov.push_back('{t0 + k, k == last_at});
   endtask

   task automatic begin_job(input int a, input int t);
      @(posedge clk); #2;
      t0 = edge_cnt;
      w0 = w_tot; if0 = if_tot; l0 = last_tot; es0 = err_sys; ess0 = err_stall;
      bus.cfg_a_rows = 7'(a);
      bus.cfg_tiles  = 5'(t);
      bus.start      = 1'b1;
   endtask

   // drop start, scramble cfg (must not matter), check busy one cycle in
   task automatic release_start();
      @(posedge clk); #2;
      bus.start      = 1'b0;
      bus.cfg_a_rows = 7'd2;
      bus.cfg_tiles  = 5'd7;
      chk("busy_running", 32'(bus.busy), 32'd1);
   endtask

   task automatic end_checks(input int ew, input int eif, input int elast);
      chk("queues_left", q_sw.size() + q_ov.size() + q_done.size(), 0);
      chk("w_reads", w_tot - w0, ew);
      chk("if_reads", if_tot - if0, eif);
      chk("of_last_count", last_tot - l0, elast);
      chk("sys_en_err", err_sys - es0, 0);
      chk("strobe_in_stall", err_stall - ess0, 0);
   endtask

   task automatic finish_job(input int n_end, input int ew, input int eif, input int elast);
      while (edge_cnt < t0 + n_end + 2) begin @(posedge clk); #2; end
      end_checks(ew, eif, elast);
      chk("busy_idle", 32'(bus.busy), 32'd0);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_w_rd",  32'(bus.w_buffer_read),  0);
      chk("rst_if_rd", 32'(bus.if_buffer_read), 0);
      chk("rst_switch", 32'(bus.switch), 0);
      chk("rst_sys_en", 32'(bus.sys_en), 1);
      chk("rst_of_valid", 32'(bus.of_valid), 0);
      chk("rst_of_last", 32'(bus.of_last), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
   endtask

   task automatic job_one_tile();
      begin_job(4, 1);
      q_sw.push_back(t0 + 9);
      push_ov(26, 29, 29);
      q_done.push_back(t0 + 30);
      release_start();
      finish_job(30, 8, 4, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      bus.start = 1'b0;
      bus.stall = 1'b0;
      bus.cfg_a_rows = '0;
      bus.cfg_tiles  = '0;
      #12;
      chk_reset_outputs();
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;

      // 1 tile, 4 rows
      job_one_tile();

      // 3 tiles, 10 rows, with a stray start mid-job that must be ignored
      begin_job(10, 3);
      q_sw.push_back(t0 + 9); q_sw.push_back(t0 + 20); q_sw.push_back(t0 + 31);
      push_ov(26, 35, -1); push_ov(37, 46, -1); push_ov(48, 57, 57);
      q_done.push_back(t0 + 58);
      release_start();
      repeat (14) @(posedge clk);
      #2;
      bus.start = 1'b1; bus.cfg_a_rows = 7'd1; bus.cfg_tiles = 5'd1;
      @(posedge clk); #2;
      bus.start = 1'b0;
      finish_job(58, 24, 30, 1);

      // 2 tiles, 3 rows: 5-cycle WWAIT before the second swap
      begin_job(3, 2);
      q_sw.push_back(t0 + 9); q_sw.push_back(t0 + 18);
      push_ov(26, 28, -1); push_ov(35, 37, 37);
      q_done.push_back(t0 + 38);
      release_start();
      finish_job(38, 16, 6, 1);

      // zero tiles: straight to done
      begin_job(5, 0);
      q_done.push_back(t0 + 1);
      release_start();
      finish_job(1, 0, 0, 0);

      // oversize row count saturates to 64
      begin_job(100, 1);
      q_sw.push_back(t0 + 9);
      push_ov(26, 89, 89);
      q_done.push_back(t0 + 90);
      release_start();
      finish_job(90, 8, 64, 1);

      // 5-cycle stall in the middle of COMP shifts everything by 5
      begin_job(10, 1);
      q_sw.push_back(t0 + 9);
      push_ov(31, 40, 40);
      q_done.push_back(t0 + 41);
      release_start();
      repeat (12) @(posedge clk);
      #2 bus.stall = 1'b1;
      repeat (5) @(posedge clk);
      #2 bus.stall = 1'b0;
      finish_job(41, 8, 10, 1);

      // reset during DRAIN while a row is on of_valid
      begin_job(4, 1);
      q_sw.push_back(t0 + 9);
      push_ov(26, 26, -1);
      release_start();
      repeat (26) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk_reset_outputs();
      end_checks(8, 4, 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;

      // clean job after the abort
      job_one_tile();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
